// File: rtl/pa_dcache_tag_ctrl.sv
// D-cache tag array access controller: arbitrates invalidate sweep, refill tag
// writes and load lookups onto the single-port tag SRAM.
module pa_dcache_tag_ctrl #(
    parameter int INDEX_LEN   = 8,
    parameter bit INIT_ON_RST = 1'b1
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    input  logic                 cp0_dcache_inv_req,
    output logic                 dcache_inv_busy,
    output logic                 dcache_inv_done,
    input  logic                 rf_tag_req,
    input  logic [INDEX_LEN-1:0] rf_tag_idx,
    input  logic                 rf_tag_way,
    input  logic [22:0]          rf_tag_din,
    output logic                 rf_tag_gnt,
    input  logic                 ld_tag_req,
    input  logic [INDEX_LEN-1:0] ld_tag_idx,
    output logic                 ld_tag_gnt,
    output logic                 ld_tag_vld,
    output logic [45:0]          ld_tag_dout,
    output logic                 tag_clk_en,
    output logic                 tag_cen,
    output logic                 tag_gwen,
    output logic [45:0]          tag_wen,
    output logic [45:0]          tag_din,
    output logic [9:0]           tag_idx,
    input  logic [45:0]          tag_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam state_e RST_STATE = INIT_ON_RST ? SWEEP : IDLE;

    state_e                 state_q;
    logic [INDEX_LEN-1:0]   sweep_idx_q;
    logic                   ld_vld_q;

    // The request is only sampled in IDLE, so a level still held during DONE
    // cannot re-trigger until the controller has passed through IDLE.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q     <= RST_STATE;
            sweep_idx_q <= '0;
            ld_vld_q    <= 1'b0;
        end else begin
            ld_vld_q <= ld_tag_gnt;
            case (state_q)
                IDLE: begin
                    if (cp0_dcache_inv_req) begin
                        state_q <= SWEEP;
                    end
                end
                SWEEP: begin
                    sweep_idx_q <= sweep_idx_q + 1'b1;
                    if (sweep_idx_q == '1) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dcache_inv_busy = (state_q == SWEEP);
    assign dcache_inv_done = (state_q == DONE);
    assign ld_tag_vld      = ld_vld_q;
    assign ld_tag_dout     = ld_vld_q ? tag_dout : 46'h0;
    assign tag_clk_en      = (state_q == SWEEP) | rf_tag_req | ld_tag_req;

    // Fixed priority: sweep, then refill, then lookup.
    always_comb begin
        rf_tag_gnt = 1'b0;
        ld_tag_gnt = 1'b0;
        tag_cen    = 1'b1;
        tag_gwen   = 1'b1;
        tag_wen    = '1;
        tag_din    = '0;
        tag_idx    = '0;
        if (state_q == SWEEP) begin
            tag_cen  = 1'b0;
            tag_gwen = 1'b0;
            tag_wen  = '0;
            tag_idx  = 10'(sweep_idx_q);
        end else if (rf_tag_req) begin
            rf_tag_gnt = 1'b1;
            tag_cen    = 1'b0;
            tag_gwen   = 1'b0;
            tag_idx    = 10'(rf_tag_idx);
            if (rf_tag_way) begin
                tag_wen = {23'h0, 23'h7F_FFFF};
                tag_din = {rf_tag_din, 23'h0};
            end else begin
                tag_wen = {23'h7F_FFFF, 23'h0};
                tag_din = {23'h0, rf_tag_din};
            end
        end else if (ld_tag_req) begin
            ld_tag_gnt = 1'b1;
            tag_cen    = 1'b0;
            tag_idx    = 10'(ld_tag_idx);
        end
    end

endmodule

// File: tb/tb_pa_dcache_tag_ctrl.sv
// Testbench for pa_dcache_tag_ctrl: a set/way-level cache model predicts every
// output each cycle; directed sequences pin a few literal values.
module tb_pa_dcache_tag_ctrl;

    localparam int IDX  = 4;
    localparam int SETS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        cpurst;
    logic        invReq;
    logic        rfReq;
    logic [3:0]  rfIdx;
    logic        rfWay;
    logic [22:0] rfDin;
    logic        ldReq;
    logic [3:0]  ldIdx;

    logic        busy, done, rfGnt, ldGnt, ldVld, clkEn, cen, gwen;
    logic [45:0] ldDout, wen, din, tagDout;
    logic [9:0]  idx;

    logic        busy2, done2, rfGnt2, ldGnt2, ldVld2, clkEn2, cen2, gwen2;
    logic [45:0] ldDout2, wen2, din2;
    logic [9:0]  idx2;
    logic [45:0] garbage2 = 46'h2AAA_AAAA_AAAA;

    int tests  = 0;
    int failed = 0;

    pa_dcache_tag_ctrl #(.INDEX_LEN(IDX), .INIT_ON_RST(1'b1)) dut (
        .forever_cpuclk(clk), .cpurst(cpurst),
        .cp0_dcache_inv_req(invReq), .dcache_inv_busy(busy), .dcache_inv_done(done),
        .rf_tag_req(rfReq), .rf_tag_idx(rfIdx), .rf_tag_way(rfWay), .rf_tag_din(rfDin),
        .rf_tag_gnt(rfGnt), .ld_tag_req(ldReq), .ld_tag_idx(ldIdx), .ld_tag_gnt(ldGnt),
        .ld_tag_vld(ldVld), .ld_tag_dout(ldDout), .tag_clk_en(clkEn), .tag_cen(cen),
        .tag_gwen(gwen), .tag_wen(wen), .tag_din(din), .tag_idx(idx), .tag_dout(tagDout)
    );

    pa_dcache_tag_ctrl #(.INDEX_LEN(IDX), .INIT_ON_RST(1'b0)) dut2 (
        .forever_cpuclk(clk), .cpurst(cpurst),
        .cp0_dcache_inv_req(1'b0), .dcache_inv_busy(busy2), .dcache_inv_done(done2),
        .rf_tag_req(1'b0), .rf_tag_idx(4'h0), .rf_tag_way(1'b0), .rf_tag_din(23'h0),
        .rf_tag_gnt(rfGnt2), .ld_tag_req(1'b0), .ld_tag_idx(4'h0), .ld_tag_gnt(ldGnt2),
        .ld_tag_vld(ldVld2), .ld_tag_dout(ldDout2), .tag_clk_en(clkEn2), .tag_cen(cen2),
        .tag_gwen(gwen2), .tag_wen(wen2), .tag_din(din2), .tag_idx(idx2), .tag_dout(garbage2)
    );

    // Single-port SRAM stand-in with bit-masked writes and one-cycle read latency.
    logic [45:0] sram [SETS];
    always @(posedge clk) begin
        if (!cen) begin
            if (!gwen) sram[idx[3:0]] <= (sram[idx[3:0]] & wen) | (din & ~wen);
            else       tagDout <= sram[idx[3:0]];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rf, input logic way, input logic [3:0] ri,
                                 input logic [22:0] rd, input logic ld, input logic [3:0] li);
        rfReq = rf; rfWay = way; rfIdx = ri; rfDin = rd;
        ldReq = ld; ldIdx = li;
    endtask

    // Cache contents per set and way, plus sweep progress counted in remaining cycles.
    logic [22:0] mWay [2][SETS];
    int          sweepLeft   = 0;
    bit          donePulse   = 1'b0;
    bit          vldPending  = 1'b0;
    bit          modelValid  = 1'b0;
    logic [45:0] pendData    = '0;

    always @(negedge clk) begin : cmpProc
        logic [45:0] eWen, eDin;
        logic [9:0]  eIdx;
        bit          eCen, eGwen, eRf, eLd, sweeping;
        int          sh;
        sweeping = (sweepLeft > 0);
        eCen = 1'b1; eGwen = 1'b1; eWen = '1; eDin = '0; eIdx = '0; eRf = 1'b0; eLd = 1'b0;
        if (modelValid && !cpurst) begin
            if (sweeping) begin
                eCen = 1'b0; eGwen = 1'b0; eWen = '0;
                eIdx = 10'(SETS - sweepLeft);
            end else if (rfReq) begin
                sh   = rfWay ? 23 : 0;
                eRf  = 1'b1; eCen = 1'b0; eGwen = 1'b0;
                eIdx = 10'(rfIdx);
                eWen = ~(46'h7F_FFFF << sh);
                eDin = {23'h0, rfDin} << sh;
            end else if (ldReq) begin
                eLd  = 1'b1; eCen = 1'b0;
                eIdx = 10'(ldIdx);
            end
            checkOutput("rf_gnt", rfGnt, eRf);
            checkOutput("ld_gnt", ldGnt, eLd);
            checkOutput("tag_cen", cen, eCen);
            checkOutput("tag_gwen", gwen, eGwen);
            checkOutput("tag_wen", wen, eWen);
            checkOutput("tag_din", din, eDin);
            checkOutput("tag_idx", idx, eIdx);
            checkOutput("tag_clk_en", clkEn, sweeping | rfReq | ldReq);
            checkOutput("busy", busy, sweeping);
            checkOutput("done", done, donePulse);
            checkOutput("ld_vld", ldVld, vldPending);
            checkOutput("ld_dout", ldDout, vldPending ? pendData : 46'h0);
        end
        if (cpurst) begin
            sweepLeft  = SETS;
            donePulse  = 1'b0;
            vldPending = 1'b0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            vldPending = eLd;
            if (eLd) pendData = {mWay[1][ldIdx], mWay[0][ldIdx]};
            if (sweeping) begin
                mWay[0][SETS - sweepLeft] = '0;
                mWay[1][SETS - sweepLeft] = '0;
                sweepLeft--;
                donePulse = (sweepLeft == 0);
            end else begin
                if (rfReq) mWay[rfWay][rfIdx] = rfDin;
                if (!donePulse && invReq) sweepLeft = SETS;
                donePulse = 1'b0;
            end
        end
    end

    initial begin
        int  busyCnt, noGntCnt;
        bit  seen, dropInv;
        for (int s = 0; s < SETS; s++) begin
            sram[s]    = 46'({$urandom, $urandom});
            mWay[0][s] = '0;
            mWay[1][s] = '0;
        end
        cpurst = 1'b1; invReq = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 23'h0, 1'b0, 4'h0);
        repeat (3) tick();
        cpurst = 1'b0;

        // Power-on sweep, and the INIT_ON_RST=0 instance staying quiet meanwhile.
        busyCnt = 0; seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checkOutput("first_sweep_idx", idx, 10'd0);
                checkOutput("first_sweep_cen", cen, 1'b0);
                checkOutput("first_sweep_wen", wen, 46'h0);
            end
            if (c < 10) begin
                checkOutput("noinit_cen", cen2, 1'b1);
                checkOutput("noinit_clk_en", clkEn2, 1'b0);
                checkOutput("noinit_vld", ldVld2, 1'b0);
                checkOutput("noinit_dout", ldDout2, 46'h0);
                checkOutput("noinit_busy", busy2, 1'b0);
            end
            if (busy) busyCnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("sweep_len", busyCnt, 16);
        checkOutput("sweep_done_seen", seen, 1'b1);
        tick();
        @(negedge clk);
        checkOutput("post_sweep_cen", cen, 1'b1);
        checkOutput("post_sweep_clk_en", clkEn, 1'b0);
        tick();

        // Refill way1 of set 3, then read it back.
        applyStimulus(1'b1, 1'b1, 4'd3, 23'h40_0ABC, 1'b0, 4'd0);
        @(negedge clk);
        checkOutput("refill_wen", wen, 46'h0000_007F_FFFF);
        checkOutput("refill_din", din, {23'h40_0ABC, 23'h0});
        checkOutput("refill_idx", idx, 10'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 23'h0, 1'b1, 4'd3);
        @(negedge clk);
        checkOutput("lookup_gnt", ldGnt, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 23'h0, 1'b0, 4'd0);
        @(negedge clk);
        checkOutput("lookup_vld", ldVld, 1'b1);
        checkOutput("lookup_way1", ldDout[45:23], 23'h40_0ABC);
        checkOutput("lookup_way0", ldDout[22:0], 23'h0);
        tick();

        // Refill and lookup collide; lookup waits one cycle.
        applyStimulus(1'b1, 1'b0, 4'd5, 23'h1_2345, 1'b1, 4'd5);
        @(negedge clk);
        checkOutput("collide_rf_gnt", rfGnt, 1'b1);
        checkOutput("collide_ld_gnt", ldGnt, 1'b0);
        checkOutput("collide_gwen", gwen, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 23'h0, 1'b1, 4'd5);
        @(negedge clk);
        checkOutput("retry_ld_gnt", ldGnt, 1'b1);
        checkOutput("retry_gwen", gwen, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 23'h0, 1'b0, 4'd0);
        @(negedge clk);
        checkOutput("retry_vld", ldVld, 1'b1);
        checkOutput("retry_dout", ldDout, {23'h0, 23'h1_2345});
        tick();

        // Invalidate while a lookup is held: blocked for the whole sweep.
        invReq = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 23'h0, 1'b1, 4'd3);
        @(negedge clk);
        checkOutput("inv_idle_ld_gnt", ldGnt, 1'b1);
        tick();
        noGntCnt = 0; seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                checkOutput("done_ld_gnt", ldGnt, 1'b1);
                break;
            end
            if (busy && !ldGnt) noGntCnt++;
            tick();
        end
        checkOutput("inv_done_seen", seen, 1'b1);
        checkOutput("sweep_blocked_cycles", noGntCnt, 16);
        tick();
        invReq = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 23'h0, 1'b0, 4'd0);
        @(negedge clk);
        checkOutput("after_inv_vld", ldVld, 1'b1);
        checkOutput("after_inv_dout", ldDout, 46'h0);
        tick();

        // Reset while the sweep is at index 7.
        invReq = 1'b1;
        tick();
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy && idx == 10'd6) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("reached_idx6", seen, 1'b1);
        tick();
        cpurst = 1'b1; invReq = 1'b0;
        tick();
        cpurst = 1'b0;
        @(negedge clk);
        checkOutput("restart_idx", idx, 10'd0);
        checkOutput("restart_busy", busy, 1'b1);
        checkOutput("restart_cen", cen, 1'b0);
        checkOutput("noinit_rst_cen", cen2, 1'b1);
        checkOutput("noinit_rst_busy", busy2, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("restart_done_seen", seen, 1'b1);
        tick();

        // Randomized traffic against the model.
        dropInv = 1'b0;
        for (int c = 0; c < 300; c++) begin
            applyStimulus($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 23'($urandom),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if (!invReq && c < 260 && $urandom_range(0, 60) == 0) invReq = 1'b1;
            @(negedge clk);
            if (invReq && done) dropInv = 1'b1;
            tick();
            if (dropInv) begin
                invReq  = 1'b0;
                dropInv = 1'b0;
            end
        end
        invReq = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 23'h0, 1'b0, 4'd0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
